alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//  Downstream capture stage for the 32-bit ALU. Each valid cycle it registers the ALU
//  result (alu_out, cout) with the op code (ctrl) that produced it, and buffers it in a
//  DEPTH-entry first-word-fall-through FIFO. The consumer drains it with a valid/ready
//  handshake. Decouples the combinational ALU from a consumer that can stall.
// PARAMETERS
//  DATA_W   32  width of alu_out / out_data
//  DEPTH    4   number of FIFO entries; power of 2, >= 2
//  STALL_W  8   width of saturating stall counter
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             upstream presents a result this cycle
//  in_ready   out  1             FIFO accepts; = ~full (registered, no out_ready path)
//  alu_out    in   DATA_W        ALU result
//  cout       in   1             ALU carry out
//  ctrl       in   2             ALU op code for this result
//  out_valid  out  1             head entry valid; = ~empty
//  out_ready  in   1             consumer takes head this cycle
//  out_data   out  DATA_W        head entry result
//  out_cout   out  1             head entry carry
//  out_ctrl   out  2             head entry op code
//  count      out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
//  full       out  1             count == DEPTH
//  empty      out  1             count == 0
//  stall_cnt  out  STALL_W       cycles with in_valid & ~in_ready, saturating
// BEHAVIOUR
//  Reset (rst_n low, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, in_ready=1,
//   out_valid=0, out_data=0, out_cout=0, out_ctrl=0, stall_cnt=0. Storage need not reset.
//  Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the same edge.
//  Storage: entry = {ctrl, cout, alu_out}, DATA_W+3 bits; write at mem[wr_ptr], wr_ptr+1.
//  Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally; count tracks fullness.
//  FWFT: out_* always show mem[rd_ptr]; when empty, out_* hold last value and out_valid=0.
//  Latency: push at edge N into empty FIFO -> out_valid=1, data visible after edge N.
//  count update: push&~pop +1; pop&~push -1; both or neither: unchanged.
//  Simultaneous push+pop when 0<count<DEPTH: both occur, count unchanged, order kept.
//  Full: in_ready=0, push is impossible; a pop in that cycle frees a slot from the next cycle.
//   No combinational out_ready->in_ready path.
//  Empty: out_valid=0; out_ready ignored, no pointer move, count never underflows.
//  Input held with in_valid while in_ready=0 must not be captured; upstream holds it stable.
//  stall_cnt: +1 on each edge with in_valid & ~in_ready; saturates at 2^STALL_W-1; never
//   wraps; cleared only by reset.
//  Reset asserted mid-operation: all contents discarded immediately; out_valid drops
//   asynchronously; first push after release lands at entry 0.
//  No arithmetic on data; fields pass through bit-exact, no width change.
// TESTING
//  1 Reset: rst_n=0 -> out_valid=0, empty=1, full=0, count=0, in_ready=1, stall_cnt=0.
//  2 Single pass: push alu_out=32'hFFFF_FFFF cout=0 ctrl=2'b00, out_ready=1 -> next cycle
//    out_valid=1, out_data=32'hFFFF_FFFF, out_cout=0, out_ctrl=00; then empty=1.
//  3 Fill/order: out_ready=0, push 3,9,12,0x7FFF_FFFE with ctrl 00,01,10,11 -> full=1,
//    count=4, in_ready=0; drain -> same four values and ctrls in order; empty after 4 pops.
//  4 Stall counter: keep FIFO full, in_valid=1 for 300 cycles -> stall_cnt=255 (saturated),
//    contents unchanged.
//  5 Push+pop at count=2 for 10 cycles with an incrementing alu_out -> count stays 2,
//    outputs stay strictly in order across pointer wrap.
//  6 Async reset with count=3 between clock edges -> out_valid=0, count=0 with no clock edge;
//    next push of 32'h0000_0005 reads back as the head.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Registers each ALU result with its op code into a DEPTH-entry first-word-fall-through FIFO.
// Latency: a push into an empty FIFO is visible on out_* one edge later.
// Backpressure: in_ready = ~full from state only; out_ready never reaches in_ready combinationally.
module alu_result_fifo #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          alu_out,
    input  logic                       cout,
    input  logic [1:0]                 ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_cout,
    output logic [1:0]                 out_ctrl,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [STALL_W-1:0]         stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]      FULL_CNT  = CW'(DEPTH);
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    typedef struct packed {
        logic [1:0]        ctrl;
        logic              cout;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    entry_t             head_q, head_d;
    entry_t             in_entry;
    logic               push, pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count     = count_q;
    assign stall_cnt = stall_cnt_q;
    assign out_data  = head_q.data;
    assign out_cout  = head_q.cout;
    assign out_ctrl  = head_q.ctrl;

    always_comb begin
        in_entry    = '{ctrl: ctrl, cout: cout, data: alu_out};
        push        = in_valid & ~full;
        pop         = out_valid & out_ready;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        head_d      = head_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        if (in_valid && !in_ready && stall_cnt_q != STALL_MAX)
            stall_cnt_d = stall_cnt_q + STALL_W'(1);

        // The new head is the slot being written this edge when it lands on the read pointer;
        // otherwise it is already in storage. An empty FIFO keeps showing its last head.
        if (count_d != '0) begin
            if (push && rd_ptr_d == wr_ptr_q) head_d = in_entry;
            else                              head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            head_q      <= head_d;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised and directed bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic        cout;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_out = '0;
    logic        cout = 1'b0;
    logic [1:0]  ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_cout;
    logic [1:0]  out_ctrl;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [7:0]  stall_cnt;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    ent_t m_last = '0;
    int   m_stall = 0;

    always #5 clk = ~clk;

    alu_result_fifo dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .cout(cout), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cout(out_cout), .out_ctrl(out_ctrl),
        .count(count), .full(full), .empty(empty), .stall_cnt(stall_cnt)
    );

    // Advance one clock and apply the same transfer to the reference queue.
    task automatic cycle();
        bit   do_push, do_pop;
        ent_t e;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        e = ent_t'({ctrl, cout, alu_out});
        if (in_valid && mq.size() == DEPTH && m_stall < 255) m_stall++;
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_stall = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, empty, full, count, in_ready, stall_cnt} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b empty=%b full=%b count=%0d rdy=%b stall=%0d",
                     out_valid, empty, full, count, in_ready, stall_cnt);
        end
        checks++;
        if ({out_ctrl, out_cout, out_data} !== 35'd0) begin
            errors++;
            $display("FAIL reset_head: got %h required 0", {out_ctrl, out_cout, out_data});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_pass();
        in_valid = 1'b1; alu_out = 32'hFFFF_FFFF; cout = 1'b0; ctrl = 2'b00; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_ctrl, out_cout, out_data} !== {1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL single_head: got v=%b %b %b %h required v=1 00 0 ffffffff",
                     out_valid, out_ctrl, out_cout, out_data);
        end
        cycle();
        checks++;
        if ({empty, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL single_empty: got empty=%b valid=%b count=%0d", empty, out_valid, count);
        end
        checks++;
        if (out_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL single_hold: got %h required ffffffff", out_data);
        end
    endtask

    task automatic test_fill_order();
        logic [31:0] vals [4];
        vals[0] = 32'd3; vals[1] = 32'd9; vals[2] = 32'd12; vals[3] = 32'h7FFF_FFFE;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; alu_out = vals[i]; ctrl = 2'(i); cout = i[0];
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if ({full, count, in_ready} !== {1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: got full=%b count=%0d rdy=%b required 1 4 0", full, count, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_ctrl, out_cout, out_data} !== {1'b1, 2'(i), i[0], vals[i]}) begin
                errors++;
                $display("FAIL fill_order[%0d]: got v=%b %b %b %h required 1 %b %b %h",
                         i, out_valid, out_ctrl, out_cout, out_data, 2'(i), i[0], vals[i]);
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL fill_drained: got empty=%b count=%0d", empty, count);
        end
    endtask

    task automatic test_stall_counter();
        ent_t head;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; alu_out = 32'h100 + 32'(i); ctrl = 2'(3 - i); cout = 1'b1;
            cycle();
        end
        head = ent_t'({out_ctrl, out_cout, out_data});
        for (int i = 0; i < 300; i++) begin
            alu_out = $urandom; ctrl = 2'($urandom); cout = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (stall_cnt !== 8'(m_stall) || stall_cnt !== 8'd255) begin
            errors++;
            $display("FAIL stall_sat: got %0d required 255 (model %0d)", stall_cnt, m_stall);
        end
        checks++;
        if ({count, out_ctrl, out_cout, out_data} !== {3'd4, 2'd3, 1'b1, 32'h100} || head !== mq[0]) begin
            errors++;
            $display("FAIL stall_contents: got count=%0d head=%h required 4 and %h",
                     count, {out_ctrl, out_cout, out_data}, ent_t'({2'd3, 1'b1, 32'h100}));
        end
    endtask

    task automatic test_push_pop_wrap();
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; alu_out = 32'h2000 + 32'(i); ctrl = 2'(i); cout = i[1];
            cycle();
            checks++;
            if (count !== 3'd2 || {out_ctrl, out_cout, out_data} !== mq[0]) begin
                errors++;
                $display("FAIL pushpop[%0d]: got count=%0d head=%h required 2 %h",
                         i, count, {out_ctrl, out_cout, out_data}, mq[0]);
            end
        end
        // After ten steady-state swaps the head is the ninth pushed value.
        checks++;
        if (out_data !== 32'h2008) begin
            errors++;
            $display("FAIL pushpop_final: got %h required 00002008", out_data);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; alu_out = 32'hABCD; ctrl = 2'b01; cout = 1'b0;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL areset_pre: got count=%0d required 3", count);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, count, empty, stall_cnt} !== {1'b0, 3'd0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL areset_async: got valid=%b count=%0d empty=%b stall=%0d",
                     out_valid, count, empty, stall_cnt);
        end
        #1 rst_n = 1'b1;
        in_valid = 1'b1; alu_out = 32'h0000_0005; ctrl = 2'b10; cout = 1'b1;
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, count, out_ctrl, out_cout, out_data} !== {1'b1, 3'd1, 2'b10, 1'b1, 32'h5}) begin
            errors++;
            $display("FAIL areset_first: got v=%b count=%0d %b %b %h required 1 1 10 1 00000005",
                     out_valid, count, out_ctrl, out_cout, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                alu_out  = $urandom; ctrl = 2'($urandom); cout = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            checks++;
            if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) || empty !== (mq.size() == 0)
                || full !== (mq.size() == DEPTH) || in_ready !== (mq.size() != DEPTH)) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got count=%0d v=%b e=%b f=%b r=%b required count=%0d",
                         i, count, out_valid, empty, full, in_ready, mq.size());
            end
            checks++;
            if ({out_ctrl, out_cout, out_data} !== m_last || stall_cnt !== 8'(m_stall)) begin
                errors++;
                $display("FAIL rand_head[%0d]: got head=%h stall=%0d required %h %0d",
                         i, {out_ctrl, out_cout, out_data}, stall_cnt, m_last, m_stall);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_fill_order();
        test_stall_counter();
        test_push_pop_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
